// File: rtl/product_csa_accumulator_pkg.sv
// Shared widths, FSM encoding and carry-save helpers for the product accumulator.
package product_csa_accumulator_pkg;

    localparam int unsigned SIG_WIDTH = 23;
    localparam int unsigned PW        = 2 * (SIG_WIDTH + 1) + 1;
    localparam int unsigned ACC_WIDTH = PW + 5;
    localparam int unsigned N_PROD    = 9;
    localparam int unsigned GROUP     = 3;
    localparam int unsigned N_BEATS   = N_PROD / GROUP;
    localparam int unsigned VEC_WIDTH = N_PROD * PW;
    localparam int unsigned GRP_WIDTH = GROUP * PW;
    localparam int unsigned N_OPS     = 2 * GROUP + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } acc_state_t;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] s;
        logic [ACC_WIDTH-1:0] c;
    } csa_pair_t;

    // One 3:2 compressor row; carry is pre-shifted and its MSB dropped.
    function automatic csa_pair_t csa3(input logic [ACC_WIDTH-1:0] a,
                                       input logic [ACC_WIDTH-1:0] b,
                                       input logic [ACC_WIDTH-1:0] d);
        csa_pair_t            r;
        logic [ACC_WIDTH-1:0] maj;
        maj = (a & b) | (a & d) | (b & d);
        r.s = a ^ b ^ d;
        r.c = {maj[ACC_WIDTH-2:0], 1'b0};
        return r;
    endfunction

    // Sign-extend a product vector to accumulator width.
    function automatic logic [ACC_WIDTH-1:0] sext_pw(input logic [PW-1:0] v);
        return {{(ACC_WIDTH - PW){v[PW-1]}}, v};
    endfunction

endpackage

// File: rtl/product_csa_accumulator_csa_tree_8to2.sv
// Combinational 8-operand carry-save compressor tree (four 3:2 levels).
module csa_tree_8to2
    import product_csa_accumulator_pkg::*;
(
    input  logic [N_OPS*ACC_WIDTH-1:0] ops,
    output logic [ACC_WIDTH-1:0]       sum,
    output logic [ACC_WIDTH-1:0]       carry
);

    logic [ACC_WIDTH-1:0] op [N_OPS];
    csa_pair_t l1a, l1b, l2a, l2b, l3, l4;

    // Unpack the flat operand bus.
    always_comb begin
        for (int i = 0; i < int'(N_OPS); i++) begin
            op[i] = ops[i*ACC_WIDTH +: ACC_WIDTH];
        end
    end

    // 8 -> 6 -> 4 -> 3 -> 2 reduction.
    always_comb begin
        l1a   = csa3(op[0], op[1], op[2]);
        l1b   = csa3(op[3], op[4], op[5]);
        l2a   = csa3(l1a.s, l1a.c, l1b.s);
        l2b   = csa3(l1b.c, op[6], op[7]);
        l3    = csa3(l2a.s, l2a.c, l2b.s);
        l4    = csa3(l3.s, l3.c, l2b.c);
        sum   = l4.s;
        carry = l4.c;
    end

endmodule

// File: rtl/product_csa_accumulator.sv
// Accumulates a batch of 9 carry-save product pairs, 3 per beat, and emits one signed sum.
module product_csa_accumulator
    import product_csa_accumulator_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VEC_WIDTH-1:0] in_s,
    input  logic [VEC_WIDTH-1:0] in_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 result_zero
);

    acc_state_t                 state;
    logic [1:0]                 cnt;
    logic [VEC_WIDTH-1:0]       buf_s;
    logic [VEC_WIDTH-1:0]       buf_c;
    logic [ACC_WIDTH-1:0]       acc_s;
    logic [ACC_WIDTH-1:0]       acc_c;
    logic [GRP_WIDTH-1:0]       grp_s;
    logic [GRP_WIDTH-1:0]       grp_c;
    logic [N_OPS*ACC_WIDTH-1:0] tree_ops;
    logic [ACC_WIDTH-1:0]       tree_sum;
    logic [ACC_WIDTH-1:0]       tree_carry;
    logic [ACC_WIDTH-1:0]       final_sum;

    // Batch buffer loads only on accept so idle-time input garbage never enters the datapath.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            buf_s <= in_s;
            buf_c <= in_c;
        end
    end

    // Select the three pairs consumed on the current beat.
    always_comb begin
        grp_s = buf_s[0 +: GRP_WIDTH];
        grp_c = buf_c[0 +: GRP_WIDTH];
        case (cnt)
            2'd0: begin
                grp_s = buf_s[0 +: GRP_WIDTH];
                grp_c = buf_c[0 +: GRP_WIDTH];
            end
            2'd1: begin
                grp_s = buf_s[GRP_WIDTH +: GRP_WIDTH];
                grp_c = buf_c[GRP_WIDTH +: GRP_WIDTH];
            end
            default: begin
                grp_s = buf_s[2*GRP_WIDTH +: GRP_WIDTH];
                grp_c = buf_c[2*GRP_WIDTH +: GRP_WIDTH];
            end
        endcase
    end

    // Tree operands: running accumulator pair followed by the sign-extended beat pairs.
    always_comb begin
        tree_ops = '0;
        tree_ops[0 +: ACC_WIDTH]         = acc_s;
        tree_ops[ACC_WIDTH +: ACC_WIDTH] = acc_c;
        for (int j = 0; j < int'(GROUP); j++) begin
            tree_ops[(2*j+2)*ACC_WIDTH +: ACC_WIDTH] = sext_pw(grp_s[j*PW +: PW]);
            tree_ops[(2*j+3)*ACC_WIDTH +: ACC_WIDTH] = sext_pw(grp_c[j*PW +: PW]);
        end
    end

    csa_tree_8to2 u_tree (
        .ops   (tree_ops),
        .sum   (tree_sum),
        .carry (tree_carry)
    );

    // Final carry-propagate add; carry-out is dropped.
    always_comb begin
        final_sum = acc_s + acc_c;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            acc_s       <= '0;
            acc_c       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            result_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc_s    <= '0;
                        acc_c    <= '0;
                        cnt      <= 2'd0;
                        in_ready <= 1'b0;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    acc_s <= tree_sum;
                    acc_c <= tree_carry;
                    if (cnt == 2'(N_BEATS - 1)) begin
                        cnt   <= 2'd0;
                        state <= SUM;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                SUM: begin
                    result      <= final_sum;
                    result_zero <= (final_sum == '0);
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_csa_accumulator.sv
// Scoreboard bench for the product carry-save accumulator.
module tb_product_csa_accumulator;
    import product_csa_accumulator_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [VEC_WIDTH-1:0] in_s;
    logic [VEC_WIDTH-1:0] in_c;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] result;
    logic                 result_zero;

    product_csa_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_s        (in_s),
        .in_c        (in_c),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_zero (result_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_WIDTH-1:0] res;
        logic                 zero;
        int                   acc_edge;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_acc = -1;
    logic ov_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain sign-extended sum of all 18 vectors.
    function automatic logic [ACC_WIDTH-1:0] model(input logic [VEC_WIDTH-1:0] s,
                                                   input logic [VEC_WIDTH-1:0] c);
        logic [ACC_WIDTH-1:0] a;
        logic [PW-1:0]        v;
        a = '0;
        for (int k = 0; k < int'(N_PROD); k++) begin
            v = s[k*PW +: PW];
            a = a + {{(ACC_WIDTH-PW){v[PW-1]}}, v};
            v = c[k*PW +: PW];
            a = a + {{(ACC_WIDTH-PW){v[PW-1]}}, v};
        end
        return a;
    endfunction

    function automatic logic [PW-1:0] rnd_pw();
        return PW'({$urandom, $urandom});
    endfunction

    // Output monitor: latency, exclusivity, and in-order result comparison.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ov_q = 1'b0;
        end else begin
            if (out_valid && !ov_q) begin
                if (sb.size() == 0) check_eq("spurious_valid", 64'd1, 64'd0);
                else check_eq("latency", 64'(cyc - sb[0].acc_edge), 64'd4);
            end
            if (out_valid) check_eq("ready_valid_excl", 64'(in_ready), 64'd0);
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("result", 64'(result), 64'(e.res));
                check_eq("result_zero", 64'(result_zero), 64'(e.zero));
            end
            ov_q = out_valid;
        end
    end

    task automatic send(input logic [VEC_WIDTH-1:0] s, input logic [VEC_WIDTH-1:0] c);
        int   t;
        exp_t e;
        @(negedge clk);
        in_s = s;
        in_c = c;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        e.res = model(s, c);
        e.zero = (e.res == '0);
        e.acc_edge = cyc + 1;
        sb.push_back(e);
        if (last_acc >= 0) check_eq("spacing_ge5", 64'((e.acc_edge - last_acc) >= 5), 64'd1);
        last_acc = e.acc_edge;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_s = {VEC_WIDTH{1'bx}};
        in_c = {VEC_WIDTH{1'bx}};
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [VEC_WIDTH-1:0] vs, vc;
        logic [ACC_WIDTH-1:0] exp5;
        int t;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_s = '0;
        in_c = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_result_zero", 64'(result_zero), 64'd0);
        rst = 1'b0;

        // 1: all zero
        send('0, '0);
        wait_drain();

        // 2: 5 + 3
        vs = '0; vc = '0;
        vs[0 +: PW] = PW'(5);
        vc[0 +: PW] = PW'(3);
        send(vs, vc);
        wait_drain();

        // 3: single -1
        vs = '0; vc = '0;
        vs[0 +: PW] = {PW{1'b1}};
        send(vs, vc);
        wait_drain();

        // 4: +7 / -7 cancellation on every pair
        for (int k = 0; k < int'(N_PROD); k++) begin
            vs[k*PW +: PW] = PW'(7);
            vc[k*PW +: PW] = PW'(0) - PW'(7);
        end
        send(vs, vc);
        wait_drain();

        // 5: max positive operands, then backpressure with an ignored second batch
        for (int k = 0; k < int'(N_PROD); k++) begin
            vs[k*PW +: PW] = {1'b0, {(PW-1){1'b1}}};
            vc[k*PW +: PW] = {1'b0, {(PW-1){1'b1}}};
        end
        exp5 = model(vs, vc);
        check_eq("model_18max", 64'(exp5), 64'd18 * ((64'd1 << 48) - 64'd1));
        out_ready = 1'b0;
        send(vs, vc);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        in_s = '0;
        in_c = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_result", 64'(result), 64'(exp5));
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
            check_eq("hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        repeat (10) @(negedge clk);
        check_eq("no_extra_valid", 64'(out_valid), 64'd0);
        check_eq("idle_in_ready", 64'(in_ready), 64'd1);

        // 6: back-to-back random batches
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < int'(N_PROD); k++) begin
                vs[k*PW +: PW] = rnd_pw();
                vc[k*PW +: PW] = rnd_pw();
            end
            send(vs, vc);
        end
        wait_drain();

        // Reset during ACC discards the batch
        for (int k = 0; k < int'(N_PROD); k++) begin
            vs[k*PW +: PW] = rnd_pw();
            vc[k*PW +: PW] = rnd_pw();
        end
        send(vs, vc);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        last_acc = -1;
        @(negedge clk);
        check_eq("abort_out_valid", 64'(out_valid), 64'd0);
        check_eq("abort_in_ready", 64'(in_ready), 64'd1);
        check_eq("abort_result", 64'(result), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("post_abort_out_valid", 64'(out_valid), 64'd0);
        check_eq("post_abort_in_ready", 64'(in_ready), 64'd1);

        // Recovery batch after abort
        vs = '0; vc = '0;
        vs[8*PW +: PW] = PW'(100);
        vc[4*PW +: PW] = PW'(0) - PW'(250);
        send(vs, vc);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
